// File: rtl/bus_pkg.sv
// Shared bus definitions: address width, broadcast address, where the
// destination address sits inside a packet, and a saturating counter helper.
package bus_pkg;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 8;
  localparam logic [ADDR_W-1:0] BROADCAST_ADDR = 8'hFF;

  // The destination address occupies the top ADDR_W bits of a packet.
  function automatic int addr_lsb(input int pckg_sz);
    return pckg_sz - ADDR_W;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO. The head entry is visible on dout
// whenever the FIFO is non-empty; dout reads 0 while empty. A push while full
// is accepted only if a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int PCKG_SZ = 16,
  parameter int DEPTH   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [PCKG_SZ-1:0] din,
  input  logic               pop,
  output logic [PCKG_SZ-1:0] dout,
  output logic               empty,
  output logic               full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [PCKG_SZ-1:0] mem [DEPTH];
  logic               wr_en;
  logic               rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; contents are discarded by pointer reset alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; the array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bus_dev_fifo.sv
// One bus drop: a TX FIFO from the local agent to the bus, an RX FIFO from
// the bus to the local monitor behind an address filter, and saturating
// drop/error counters.
module bus_dev_fifo
  import bus_pkg::*;
#(
  parameter int                PCKG_SZ   = 16,
  parameter int                DEPTH     = 8,
  parameter logic [ADDR_W-1:0] DEV_ID    = '0,
  parameter logic [ADDR_W-1:0] BROADCAST = BROADCAST_ADDR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               agt_push,
  input  logic [PCKG_SZ-1:0] agt_din,
  output logic               agt_full,
  output logic               pndng,
  output logic [PCKG_SZ-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [PCKG_SZ-1:0] D_push,
  output logic               mon_valid,
  output logic [PCKG_SZ-1:0] mon_data,
  input  logic               mon_ready,
  output logic [CNT_W-1:0]   tx_ovf_cnt,
  output logic [CNT_W-1:0]   rx_ovf_cnt,
  output logic [CNT_W-1:0]   rx_adr_err_cnt
);

  localparam int ALSB = addr_lsb(PCKG_SZ);

  logic              tx_empty;
  logic              rx_empty;
  logic              rx_full;
  logic [ADDR_W-1:0] rx_addr;
  logic              addr_ok;
  logic              rx_push;

  assign rx_addr   = D_push[ALSB +: ADDR_W];
  assign addr_ok   = (rx_addr == DEV_ID) || (rx_addr == BROADCAST);
  assign rx_push   = push & addr_ok;
  assign pndng     = ~tx_empty;
  assign mon_valid = ~rx_empty;

  sync_fifo_fwft #(.PCKG_SZ(PCKG_SZ), .DEPTH(DEPTH)) u_tx (
    .clk   (clk),
    .reset (reset),
    .push  (agt_push),
    .din   (agt_din),
    .pop   (pop),
    .dout  (D_pop),
    .empty (tx_empty),
    .full  (agt_full)
  );

  sync_fifo_fwft #(.PCKG_SZ(PCKG_SZ), .DEPTH(DEPTH)) u_rx (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .din   (D_push),
    .pop   (mon_ready),
    .dout  (mon_data),
    .empty (rx_empty),
    .full  (rx_full)
  );

  // Drop and address-error counters; they stick at all-ones rather than wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ovf_cnt     <= '0;
      rx_ovf_cnt     <= '0;
      rx_adr_err_cnt <= '0;
    end else begin
      if (agt_push && agt_full && !pop)
        tx_ovf_cnt <= sat_inc(tx_ovf_cnt);
      if (rx_push && rx_full && !mon_ready)
        rx_ovf_cnt <= sat_inc(rx_ovf_cnt);
      if (push && !addr_ok)
        rx_adr_err_cnt <= sat_inc(rx_adr_err_cnt);
    end
  end

endmodule

// File: doc/bus_dev_fifo.md
BUS_DEV_FIFO -- requirements
Module: bus_dev_fifo

Interface
REQ-001 SHALL have parameter PCKG_SZ, default 16, bus packet width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entries per FIFO; power of two, at least 2.
REQ-003 SHALL have parameter DEV_ID, default 0, 8-bit device address of this bus drop.
REQ-004 SHALL have parameter BROADCAST, default 8'hFF, 8-bit broadcast address.
REQ-005 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port: agt_push  in  1  agent writes one packet into TX FIFO.
REQ-008 SHALL have port: agt_din  in  PCKG_SZ  agent packet; bits [PCKG_SZ-1 -: 8] hold destination address.
REQ-009 SHALL have port: agt_full  out  1  TX FIFO full.
REQ-010 SHALL have port: pndng  out  1  TX FIFO non-empty, to bus arbiter.
REQ-011 SHALL have port: D_pop  out  PCKG_SZ  TX head packet, to bus.
REQ-012 SHALL have port: pop  in  1  bus consumes TX head.
REQ-013 SHALL have port: push  in  1  bus delivers one packet.
REQ-014 SHALL have port: D_push  in  PCKG_SZ  delivered packet.
REQ-015 SHALL have port: mon_valid  out  1  RX FIFO non-empty.
REQ-016 SHALL have port: mon_data  out  PCKG_SZ  RX head packet.
REQ-017 SHALL have port: mon_ready  in  1  monitor consumes RX head.
REQ-018 SHALL have port: tx_ovf_cnt  out  8  agent pushes dropped because TX was full.
REQ-019 SHALL have port: rx_ovf_cnt  out  8  bus pushes dropped because RX was full.
REQ-020 SHALL have port: rx_adr_err_cnt  out  8  bus pushes rejected by the address filter.

Function
REQ-021 SHALL implement TX as a first-word-fall-through FIFO: pndng = !empty; D_pop = head entry, or 0 when empty.
REQ-022 SHALL accept agt_push when not full, or when full with pop in the same cycle (simultaneous write and read, occupancy unchanged).
REQ-023 SHALL drop agt_push when full and pop=0, incrementing tx_ovf_cnt.
REQ-024 SHALL ignore pop when TX is empty; push and pop together on empty stores the packet, with pndng=1 next cycle.
REQ-025 SHALL accept a bus push into RX only when D_push[PCKG_SZ-1 -: 8] equals DEV_ID or BROADCAST.
REQ-026 SHALL reject a bus push with any other address: data not stored, rx_adr_err_cnt increments.
REQ-027 SHALL drop an address-valid push when RX is full and mon_ready=0, incrementing rx_ovf_cnt.
REQ-028 SHALL perform an RX read on mon_valid & mon_ready; mon_data is the FWFT head, or 0 when empty.
REQ-029 SHALL make each write visible at the FIFO output on the cycle after the write edge (1-cycle latency).
REQ-030 SHALL wrap pointers modulo DEPTH and keep an extra wrap bit to distinguish full from empty.
REQ-031 SHALL saturate all counters at 8'hFF, with no wrap to 0.
REQ-032 SHALL drive agt_full, pndng and mon_valid directly from registered pointers, with no combinational path from any input.

Reset
REQ-033 SHALL, while reset=1, asynchronously clear pointers and counters, giving pndng=0, D_pop=0, agt_full=0, mon_valid=0, mon_data=0.
REQ-034 SHALL discard in-flight contents when reset asserts mid-operation, and ignore all inputs until the first edge after deassertion.
REQ-035 SHALL not reset the storage arrays; outputs are masked to 0 while empty.

Structure
REQ-036 SHALL take ADDR_W=8, BROADCAST_ADDR=8'hFF and the packet address field position from shared package bus_pkg.
REQ-037 SHALL instantiate sub-module sync_fifo_fwft (PCKG_SZ, DEPTH; ports push, din, pop, dout, empty, full) twice, once for TX and once for RX.
REQ-038 SHALL keep the address filter and the saturating counters in bus_dev_fifo.

Verification
REQ-039 SHALL cover: reset, then 8 agt_push of 16'h0101..16'h0108 -> agt_full=1, pndng=1, D_pop=16'h0101.
REQ-040 SHALL cover: full TX, then agt_push 16'h0109 with pop=0 -> tx_ovf_cnt=1, contents unchanged; repeat with pop=1 -> accepted, D_pop=16'h0102.
REQ-041 SHALL cover: DEV_ID=3, push D_push=16'h0355 then 16'hFF77 then 16'h0511 -> RX holds 16'h0355, 16'hFF77; rx_adr_err_cnt=1.
REQ-042 SHALL cover: RX full, mon_ready=0, push 16'h03AA -> rx_ovf_cnt=1; same push with mon_ready=1 -> accepted.
REQ-043 SHALL cover: 300 dropped agt_push -> tx_ovf_cnt=8'hFF.
REQ-044 SHALL cover: reset asserted mid-stream with 4 entries queued -> same-cycle pndng=0 and D_pop=0; after release, first push reappears with 1-cycle latency.
